// File: rtl/shift_restore_pkg.sv
// Shared state encodings and default sizes for the shift-restore (right-shift denormaliser) unit.
// Optional sticky output is controlled by the SHIFT_RESTORE_STICKY_EN macro.
package shift_restore_pkg;

    localparam int STATE_W   = 3;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3
    } state_t;

endpackage

// File: rtl/shift_restore_datapath.sv
// Data register, down-counter and termination flags for the shift-restore unit.
// With SHIFT_RESTORE_STICKY_EN defined it also keeps the OR of all shifted-out bits.
module shift_restore_datapath
    import shift_restore_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld,
    input  logic             i_shr,
    input  logic             i_clr_sticky,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [CNT_W-1:0] i_shamt_in,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ld_zero,
    output logic             o_cnt_one,
    output logic             o_shr_zero
`ifdef SHIFT_RESTORE_STICKY_EN
    ,
    output logic             o_sticky
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_shamt_clamped;

    // Shifting by WIDTH or more always yields zero, so the count saturates there.
    assign w_shamt_clamped = (int'(i_shamt_in) >= WIDTH) ? CNT_MAX : i_shamt_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_ld) begin
            r_data <= i_data_in;
            r_cnt  <= w_shamt_clamped;
        end else if (i_shr) begin
            r_data <= r_data >> 1;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Flags describe the value about to be loaded / about to be produced by the next shift.
    assign o_ld_zero  = (w_shamt_clamped == '0) || (i_data_in == '0);
    assign o_cnt_one  = (r_cnt == CNT_W'(1));
    assign o_shr_zero = (r_data[WIDTH-1:1] == '0);
    assign o_data     = r_data;

`ifdef SHIFT_RESTORE_STICKY_EN
    logic r_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (i_clr_sticky) begin
            r_sticky <= 1'b0;
        end else if (i_shr) begin
            r_sticky <= r_sticky | r_data[0];
        end
    end

    assign o_sticky = r_sticky;
`else
    logic w_unused_clr_sticky;
    assign w_unused_clr_sticky = i_clr_sticky;
`endif

endmodule

// File: rtl/shift_restore_unit.sv
// Iterative right-shift denormaliser: start press/release handshake, one shift per clock, one-cycle done.
// Optional sticky output is controlled by the SHIFT_RESTORE_STICKY_EN macro.
module shift_restore_unit
    import shift_restore_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] shamt_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
`ifdef SHIFT_RESTORE_STICKY_EN
    ,
    output logic             sticky
`endif
);

    state_t r_state;
    state_t w_state_next;
    logic   w_ld;
    logic   w_shr;
    logic   w_clr_sticky;
    logic   w_ld_zero;
    logic   w_cnt_one;
    logic   w_shr_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ld         = 1'b0;
        w_shr        = 1'b0;
        w_clr_sticky = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = INIT;
            end
            INIT: begin
                w_ld         = 1'b1;
                w_clr_sticky = 1'b1;
                if (!start) w_state_next = w_ld_zero ? DONE : SHIFT;
            end
            SHIFT: begin
                w_shr = 1'b1;
                // Leave on the last counted shift, or as soon as further shifts cannot change the value.
                if (w_cnt_one || w_shr_zero) w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign busy = (r_state == INIT) || (r_state == SHIFT);
    assign done = (r_state == DONE);

    shift_restore_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .i_ld         (w_ld),
        .i_shr        (w_shr),
        .i_clr_sticky (w_clr_sticky),
        .i_data_in    (data_in),
        .i_shamt_in   (shamt_in),
        .o_data       (data_out),
        .o_ld_zero    (w_ld_zero),
        .o_cnt_one    (w_cnt_one),
        .o_shr_zero   (w_shr_zero)
`ifdef SHIFT_RESTORE_STICKY_EN
        ,
        .o_sticky     (sticky)
`endif
    );

endmodule

// File: doc/shift_restore_unit.md
Name: shift_restore_unit

Overview:
- Iterative right-shift denormaliser. Takes a left-normalised value plus the shift count recorded during normalisation and shifts it back right, one bit per clock, to restore the original magnitude.
- Sits downstream of the normalising left-shift stage of the abstract multiplier datapath.
- Uses the same start-press/release handshake and the same single-cycle done pulse as the rest of the design.

Parameters:
- WIDTH, 16, data width of data_in and data_out.
- CNT_W, 5, width of the shift-amount input and the internal down-counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level request; the operation begins after start is released.
- data_in  in  WIDTH  normalised value; sampled every cycle in INIT.
- shamt_in  in  CNT_W  right-shift count; sampled every cycle in INIT.
- busy  out  1  high in INIT and SHIFT.
- done  out  1  one-cycle pulse in DONE.
- data_out  out  WIDTH  restored value; registered.
- sticky  out  1  present only with STICKY_EN.

Behaviour:
- Reset (async): state=IDLE; data register=0; counter=0; busy=0; done=0; data_out=0; sticky=0. Reset mid-operation aborts immediately; no done pulse.
- States (3-bit): IDLE=0, INIT=1, SHIFT=2, DONE=3. Encodings 4-7 go to IDLE.
- IDLE: start=1 -> INIT; otherwise stay in IDLE.
- INIT:
  - Each cycle load data register <= data_in and counter <= min(shamt_in, WIDTH).
  - Stay while start=1.
  - On start=0: go to DONE if the loaded count is 0 or the loaded data is 0; otherwise go to SHIFT.
- SHIFT:
  - Each cycle: data register <= data register >> 1 (zero fill); counter <= counter - 1.
  - Go to DONE when counter==1 (the last shift is taken on that edge) or when the shifted result is 0 (early exit).
  - Otherwise stay in SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- data_out is driven directly by the data register. It is stable from DONE until the next INIT load.
- Latency: entry into DONE occurs min(n, k) + 1 edges after the first edge that samples start=0 in INIT.
  - n = clamped shamt.
  - k = number of shifts needed to reach 0 = bit index of the MSB set + 1.
- start is ignored in SHIFT and DONE. Holding start high through DONE restarts at IDLE -> INIT.
- Clamp: shamt_in >= WIDTH behaves as WIDTH and yields data_out=0.
- Outputs are decoded from the present state only (Moore).

Optional Feature:
- Macro: SHIFT_RESTORE_STICKY_EN.
- Defined:
  - Port sticky exists.
  - Cleared in INIT.
  - In SHIFT, sticky <= sticky | data_register[0] each shift, i.e. it is the OR of all shifted-out bits.
  - Held through DONE until the next INIT.
- Undefined: no sticky port and no sticky logic. All other behaviour is identical.

Decomposition:
- Package shift_restore_pkg holds:
  - state encodings IDLE/INIT/SHIFT/DONE;
  - state width constant 3;
  - default WIDTH and CNT_W.
- Sub-module shift_restore_datapath holds the data register, down-counter, zero and count==1 flags, and the sticky register. Its controls are ld, shr, clr_sticky.
- The top module holds the FSM and instantiates the datapath.

Test Plan:
- Basic shift: data_in=16'hB000, shamt=4, start high 3 cycles then low -> SHIFT for 4 cycles; done pulse; data_out=16'h0B00; sticky=0.
- Zero count: shamt=0, data_in=16'h8001 -> DONE one edge after start falls; data_out=16'h8001; no SHIFT cycles.
- Early exit: data_in=16'h0004, shamt=10 -> DONE after 3 shifts; data_out=0; with STICKY_EN, sticky=1.
- Clamp: shamt=5'd20, data_in=16'hFFFF -> data_out=0 after 16 shifts; sticky=1 when enabled.
- Sticky off: data_in=16'h0F00, shamt=8 -> data_out=16'h000F; sticky=0.
- Reset mid-SHIFT (after 2 of 6 shifts) -> busy=0, done=0, data_out=0 asynchronously. A new operation afterwards completes correctly.
